// File: rtl/cache_axi_bridge.sv
// cache_axi_bridge: icache/dcache request ports to a single AXI4 master with one read and one write in flight
module cache_axi_bridge #(
  parameter int LINE_BEATS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ic_rd_req,
  input  logic [2:0]   ic_rd_type,
  input  logic [31:0]  ic_rd_addr,
  output logic         ic_rd_rdy,
  output logic         ic_ret_valid,
  output logic         ic_ret_last,
  output logic [31:0]  ic_ret_data,
  input  logic         dc_rd_req,
  input  logic [2:0]   dc_rd_type,
  input  logic [31:0]  dc_rd_addr,
  output logic         dc_rd_rdy,
  output logic         dc_ret_valid,
  output logic         dc_ret_last,
  output logic [31:0]  dc_ret_data,
  input  logic         dc_wr_req,
  input  logic [2:0]   dc_wr_type,
  input  logic [31:0]  dc_wr_addr,
  input  logic [3:0]   dc_wr_wstrb,
  input  logic [127:0] dc_wr_data,
  output logic         dc_wr_rdy,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);
  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic [31:0]  r_addr, w_addr;
  logic [2:0]   r_type, w_type;
  logic         r_owner, aw_done, w_done, raw, aw_fire, w_fire;
  logic [3:0]   w_strb;
  logic [127:0] w_data;
  logic [1:0]   cnt;
  logic         unused_resp;
  assign unused_resp  = ^{rid, rresp, bid, bresp};
  assign raw          = (w_state != W_IDLE) && (dc_rd_addr[31:4] == w_addr[31:4]);
  assign dc_rd_rdy    = !reset && r_state == R_IDLE && dc_rd_req && !raw;
  assign ic_rd_rdy    = !reset && r_state == R_IDLE && ic_rd_req && !dc_rd_rdy;
  assign arid         = {3'b000, r_owner};
  assign araddr       = r_addr;
  assign arlen        = r_type == 3'b100 ? 8'(LINE_BEATS - 1) : 8'd0;
  assign arsize       = r_type[2] ? 3'd2 : {1'b0, r_type[1:0]};
  assign arburst      = 2'b01;
  assign arvalid      = !reset && r_state == R_AR;
  assign rready       = !reset && r_state == R_DATA;
  assign ic_ret_valid = rready && rvalid && !r_owner;
  assign dc_ret_valid = rready && rvalid && r_owner;
  assign ic_ret_last  = ic_ret_valid && rlast;
  assign dc_ret_last  = dc_ret_valid && rlast;
  assign ic_ret_data  = rdata;
  assign dc_ret_data  = rdata;
  assign dc_wr_rdy    = !reset && w_state == W_IDLE;
  assign awid         = 4'd1;
  assign awaddr       = w_addr;
  assign awlen        = w_type == 3'b100 ? 8'(LINE_BEATS - 1) : 8'd0;
  assign awsize       = w_type[2] ? 3'd2 : {1'b0, w_type[1:0]};
  assign awburst      = 2'b01;
  assign awvalid      = !reset && w_state == W_SEND && !aw_done;
  assign wvalid       = !reset && w_state == W_SEND && !w_done;
  assign wdata        = w_data[32*cnt +: 32];
  assign wstrb        = w_type == 3'b100 ? 4'hf : w_strb;
  assign wlast        = cnt == awlen[1:0];
  assign bready       = !reset && w_state == W_RESP;
  assign aw_fire      = awvalid && awready;
  assign w_fire       = wvalid && wready;
  // next-state logic for both channel FSMs
  always_comb begin
    r_next = r_state == R_IDLE ? ((dc_rd_rdy || ic_rd_rdy) ? R_AR : R_IDLE)
           : r_state == R_AR   ? (arready ? R_DATA : R_AR)
           : (rvalid && rlast) ? R_IDLE : R_DATA;
    w_next = w_state == W_IDLE ? (dc_wr_req ? W_SEND : W_IDLE)
           : w_state == W_SEND ? (((aw_done || aw_fire) && (w_done || (w_fire && wlast))) ? W_RESP : W_SEND)
           : bvalid ? W_IDLE : W_RESP;
  end
  // read request latch, dcache wins when both are accepted-eligible
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_type  <= '0;
      r_owner <= 1'b0;
    end else begin
      r_state <= r_next;
      if (dc_rd_rdy || ic_rd_rdy) begin
        r_addr  <= dc_rd_rdy ? dc_rd_addr : ic_rd_addr;
        r_type  <= dc_rd_rdy ? dc_rd_type : ic_rd_type;
        r_owner <= dc_rd_rdy;
      end
    end
  end
  // write buffer and per-channel completion tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_type  <= '0;
      w_strb  <= '0;
      w_data  <= '0;
      cnt     <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (dc_wr_rdy && dc_wr_req) begin
        w_addr  <= dc_wr_addr;
        w_type  <= dc_wr_type;
        w_strb  <= dc_wr_wstrb;
        w_data  <= dc_wr_data;
        cnt     <= '0;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        if (aw_fire) aw_done <= 1'b1;
        if (w_fire) cnt <= cnt + 2'd1;
        if (w_fire && wlast) w_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb_cache_axi_bridge: directed checks of the cache to AXI bridge
module tb_cache_axi_bridge;
  logic         clk = 0, reset = 0;
  logic         ic_rd_req = 0, dc_rd_req = 0, dc_wr_req = 0;
  logic [2:0]   ic_rd_type = 0, dc_rd_type = 0, dc_wr_type = 0;
  logic [31:0]  ic_rd_addr = 0, dc_rd_addr = 0, dc_wr_addr = 0;
  logic [3:0]   dc_wr_wstrb = 0;
  logic [127:0] dc_wr_data = 0;
  logic         ic_rd_rdy, ic_ret_valid, ic_ret_last, dc_rd_rdy, dc_ret_valid, dc_ret_last, dc_wr_rdy;
  logic [31:0]  ic_ret_data, dc_ret_data;
  logic [3:0]   arid, awid, wstrb;
  logic [31:0]  araddr, awaddr, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst;
  logic         arvalid, rready, awvalid, wlast, wvalid, bready;
  logic         arready = 0, rlast = 0, rvalid = 0, awready = 0, wready = 0, bvalid = 0;
  logic [3:0]   rid = 0, bid = 0;
  logic [1:0]   rresp = 0, bresp = 0;
  logic [31:0]  rdata = 0;
  int n_chk = 0, n_fail = 0;

  cache_axi_bridge dut (
    .clk(clk), .reset(reset),
    .ic_rd_req(ic_rd_req), .ic_rd_type(ic_rd_type), .ic_rd_addr(ic_rd_addr), .ic_rd_rdy(ic_rd_rdy),
    .ic_ret_valid(ic_ret_valid), .ic_ret_last(ic_ret_last), .ic_ret_data(ic_ret_data),
    .dc_rd_req(dc_rd_req), .dc_rd_type(dc_rd_type), .dc_rd_addr(dc_rd_addr), .dc_rd_rdy(dc_rd_rdy),
    .dc_ret_valid(dc_ret_valid), .dc_ret_last(dc_ret_last), .dc_ret_data(dc_ret_data),
    .dc_wr_req(dc_wr_req), .dc_wr_type(dc_wr_type), .dc_wr_addr(dc_wr_addr), .dc_wr_wstrb(dc_wr_wstrb),
    .dc_wr_data(dc_wr_data), .dc_wr_rdy(dc_wr_rdy),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task test_reset;
    reset = 1; ic_rd_req = 1; dc_rd_req = 1; dc_wr_req = 1; rvalid = 1; rlast = 1;
    @(negedge clk); #1;
    n_chk++; if ({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy} !== 3'b000) begin n_fail++; $display("FAIL rst_rdy got %b want 000", {ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}); end
    n_chk++; if ({arvalid, rready, awvalid, wvalid, bready} !== 5'b0) begin n_fail++; $display("FAIL rst_axi got %b want 00000", {arvalid, rready, awvalid, wvalid, bready}); end
    n_chk++; if ({ic_ret_valid, dc_ret_valid, ic_ret_last, dc_ret_last} !== 4'b0) begin n_fail++; $display("FAIL rst_ret got %b want 0000", {ic_ret_valid, dc_ret_valid, ic_ret_last, dc_ret_last}); end
    @(negedge clk); ic_rd_req = 0; dc_rd_req = 0; dc_wr_req = 0; rvalid = 0; rlast = 0; reset = 0; #1;
    n_chk++; if ({dc_wr_rdy, arvalid, rready} !== 3'b100) begin n_fail++; $display("FAIL rst_release got %b want 100", {dc_wr_rdy, arvalid, rready}); end
  endtask

  task test_ic_line_read;
    @(negedge clk); ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1c000040; #1;
    n_chk++; if ({ic_rd_rdy, dc_rd_rdy, arvalid} !== 3'b100) begin n_fail++; $display("FAIL icl_accept got %b want 100", {ic_rd_rdy, dc_rd_rdy, arvalid}); end
    @(negedge clk); ic_rd_req = 0; #1;
    n_chk++; if ({arvalid, araddr, arlen, arsize, arid, arburst} !== {1'b1, 32'h1c000040, 8'd3, 3'd2, 4'd0, 2'b01}) begin n_fail++; $display("FAIL icl_ar got %h want %h", {arvalid, araddr, arlen, arsize, arid, arburst}, {1'b1, 32'h1c000040, 8'd3, 3'd2, 4'd0, 2'b01}); end
    @(negedge clk); #1;
    n_chk++; if ({arvalid, araddr, arlen} !== {1'b1, 32'h1c000040, 8'd3}) begin n_fail++; $display("FAIL icl_ar_hold got %h want %h", {arvalid, araddr, arlen}, {1'b1, 32'h1c000040, 8'd3}); end
    arready = 1;
    @(negedge clk); arready = 0; #1;
    n_chk++; if ({arvalid, rready} !== 2'b01) begin n_fail++; $display("FAIL icl_rdata_state got %b want 01", {arvalid, rready}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rvalid = 1; rdata = 32'(32'h11 * (i + 1)); rlast = (i == 3); #1;
      n_chk++; if ({ic_ret_valid, ic_ret_last, dc_ret_valid, ic_ret_data} !== {1'b1, i == 3, 1'b0, 32'(32'h11 * (i + 1))}) begin n_fail++; $display("FAIL icl_beat%0d got %h want %h", i, {ic_ret_valid, ic_ret_last, dc_ret_valid, ic_ret_data}, {1'b1, i == 3, 1'b0, 32'(32'h11 * (i + 1))}); end
    end
    @(negedge clk); rvalid = 0; rlast = 0; #1;
    n_chk++; if ({rready, ic_ret_valid} !== 2'b00) begin n_fail++; $display("FAIL icl_done got %b want 00", {rready, ic_ret_valid}); end
  endtask

  task test_priority;
    @(negedge clk); ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h100; dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h200; #1;
    n_chk++; if ({dc_rd_rdy, ic_rd_rdy} !== 2'b10) begin n_fail++; $display("FAIL pri_accept got %b want 10", {dc_rd_rdy, ic_rd_rdy}); end
    @(negedge clk); dc_rd_req = 0; #1;
    n_chk++; if ({arvalid, arid, araddr, arlen, arsize, ic_rd_rdy} !== {1'b1, 4'd1, 32'h200, 8'd0, 3'd2, 1'b0}) begin n_fail++; $display("FAIL pri_dc_ar got %h want %h", {arvalid, arid, araddr, arlen, arsize, ic_rd_rdy}, {1'b1, 4'd1, 32'h200, 8'd0, 3'd2, 1'b0}); end
    arready = 1;
    @(negedge clk); arready = 0; rvalid = 1; rlast = 1; rdata = 32'hab; #1;
    n_chk++; if ({dc_ret_valid, dc_ret_last, dc_ret_data, ic_ret_valid, ic_rd_rdy} !== {2'b11, 32'hab, 2'b00}) begin n_fail++; $display("FAIL pri_dc_ret got %h want %h", {dc_ret_valid, dc_ret_last, dc_ret_data, ic_ret_valid, ic_rd_rdy}, {2'b11, 32'hab, 2'b00}); end
    @(negedge clk); rvalid = 0; rlast = 0; #1;
    n_chk++; if (ic_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL pri_ic_accept got %b want 1", ic_rd_rdy); end
    @(negedge clk); ic_rd_req = 0; #1;
    n_chk++; if ({arvalid, arid, araddr} !== {1'b1, 4'd0, 32'h100}) begin n_fail++; $display("FAIL pri_ic_ar got %h want %h", {arvalid, arid, araddr}, {1'b1, 4'd0, 32'h100}); end
    arready = 1;
    @(negedge clk); arready = 0; rvalid = 1; rlast = 1; rdata = 32'h55; #1;
    n_chk++; if ({ic_ret_valid, ic_ret_last, ic_ret_data, dc_ret_valid} !== {2'b11, 32'h55, 1'b0}) begin n_fail++; $display("FAIL pri_ic_ret got %h want %h", {ic_ret_valid, ic_ret_last, ic_ret_data, dc_ret_valid}, {2'b11, 32'h55, 1'b0}); end
    @(negedge clk); rvalid = 0; rlast = 0;
  endtask

  task test_line_write;
    @(negedge clk); dc_wr_req = 1; dc_wr_type = 3'b100; dc_wr_addr = 32'h1230; dc_wr_wstrb = 4'h3;
    dc_wr_data = 128'h000000d3_000000d2_000000d1_000000d0; #1;
    n_chk++; if (dc_wr_rdy !== 1'b1) begin n_fail++; $display("FAIL lw_rdy got %b want 1", dc_wr_rdy); end
    @(negedge clk); dc_wr_req = 0; wready = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      awready = (i == 3); #1;
      n_chk++; if ({awvalid, awaddr, awlen, awsize, awid, awburst} !== {1'b1, 32'h1230, 8'd3, 3'd2, 4'd1, 2'b01}) begin n_fail++; $display("FAIL lw_aw%0d got %h want %h", i, {awvalid, awaddr, awlen, awsize, awid, awburst}, {1'b1, 32'h1230, 8'd3, 3'd2, 4'd1, 2'b01}); end
      n_chk++; if ({wvalid, wdata, wstrb, wlast} !== {1'b1, 32'(32'hd0 + i), 4'hf, i == 3}) begin n_fail++; $display("FAIL lw_w%0d got %h want %h", i, {wvalid, wdata, wstrb, wlast}, {1'b1, 32'(32'hd0 + i), 4'hf, i == 3}); end
    end
    @(negedge clk); awready = 0; #1;
    n_chk++; if ({awvalid, wvalid, bready, dc_wr_rdy} !== 4'b0010) begin n_fail++; $display("FAIL lw_resp got %b want 0010", {awvalid, wvalid, bready, dc_wr_rdy}); end
    @(negedge clk); #1;
    n_chk++; if ({bready, dc_wr_rdy} !== 2'b10) begin n_fail++; $display("FAIL lw_bhold got %b want 10", {bready, dc_wr_rdy}); end
    bvalid = 1;
    @(negedge clk); bvalid = 0; wready = 0; #1;
    n_chk++; if ({bready, dc_wr_rdy} !== 2'b01) begin n_fail++; $display("FAIL lw_done got %b want 01", {bready, dc_wr_rdy}); end
  endtask

  task test_byte_write;
    @(negedge clk); dc_wr_req = 1; dc_wr_type = 3'b000; dc_wr_addr = 32'hbfaf8001; dc_wr_wstrb = 4'b0010;
    dc_wr_data = 128'h11111111_22222222_33333333_a1b2c3d4;
    @(negedge clk); dc_wr_req = 0; awready = 1; wready = 0; #1;
    n_chk++; if ({awvalid, awaddr, awlen, awsize} !== {1'b1, 32'hbfaf8001, 8'd0, 3'd0}) begin n_fail++; $display("FAIL bw_aw got %h want %h", {awvalid, awaddr, awlen, awsize}, {1'b1, 32'hbfaf8001, 8'd0, 3'd0}); end
    n_chk++; if ({wvalid, wdata, wstrb, wlast} !== {1'b1, 32'ha1b2c3d4, 4'b0010, 1'b1}) begin n_fail++; $display("FAIL bw_w got %h want %h", {wvalid, wdata, wstrb, wlast}, {1'b1, 32'ha1b2c3d4, 4'b0010, 1'b1}); end
    @(negedge clk); awready = 0; wready = 1; #1;
    n_chk++; if ({awvalid, wvalid, wlast, bready} !== 4'b0110) begin n_fail++; $display("FAIL bw_w_late got %b want 0110", {awvalid, wvalid, wlast, bready}); end
    @(negedge clk); wready = 0; #1;
    n_chk++; if ({wvalid, bready} !== 2'b01) begin n_fail++; $display("FAIL bw_resp got %b want 01", {wvalid, bready}); end
    bvalid = 1;
    @(negedge clk); bvalid = 0; #1;
    n_chk++; if (dc_wr_rdy !== 1'b1) begin n_fail++; $display("FAIL bw_done got %b want 1", dc_wr_rdy); end
  endtask

  task test_raw;
    @(negedge clk); dc_wr_req = 1; dc_wr_type = 3'b010; dc_wr_addr = 32'h1230; dc_wr_wstrb = 4'hf; awready = 1; wready = 1;
    @(negedge clk); dc_wr_req = 0; dc_rd_req = 1; dc_rd_type = 3'b010; dc_rd_addr = 32'h1234; #1;
    n_chk++; if ({dc_rd_rdy, awvalid, wvalid} !== 3'b011) begin n_fail++; $display("FAIL raw_send got %b want 011", {dc_rd_rdy, awvalid, wvalid}); end
    @(negedge clk); awready = 0; wready = 0; #1;
    n_chk++; if ({dc_rd_rdy, bready} !== 2'b01) begin n_fail++; $display("FAIL raw_resp got %b want 01", {dc_rd_rdy, bready}); end
    @(negedge clk); bvalid = 1; #1;
    n_chk++; if (dc_rd_rdy !== 1'b0) begin n_fail++; $display("FAIL raw_bvalid got %b want 0", dc_rd_rdy); end
    @(negedge clk); bvalid = 0; #1;
    n_chk++; if (dc_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL raw_release got %b want 1", dc_rd_rdy); end
    @(negedge clk); dc_rd_req = 0; #1;
    n_chk++; if ({arvalid, araddr, arid} !== {1'b1, 32'h1234, 4'd1}) begin n_fail++; $display("FAIL raw_ar got %h want %h", {arvalid, araddr, arid}, {1'b1, 32'h1234, 4'd1}); end
    arready = 1;
    @(negedge clk); arready = 0; rvalid = 1; rlast = 1; rdata = 32'h7;
    @(negedge clk); rvalid = 0; rlast = 0; dc_wr_req = 1; dc_wr_addr = 32'h1230; #1;
    n_chk++; if (dc_wr_rdy !== 1'b1) begin n_fail++; $display("FAIL raw_wr2_rdy got %b want 1", dc_wr_rdy); end
    @(negedge clk); dc_wr_req = 0; dc_rd_req = 1; dc_rd_addr = 32'h2000; awready = 1; wready = 1; #1;
    n_chk++; if (dc_rd_rdy !== 1'b1) begin n_fail++; $display("FAIL raw_other_line got %b want 1", dc_rd_rdy); end
    @(negedge clk); dc_rd_req = 0; awready = 0; wready = 0; #1;
    n_chk++; if ({arvalid, araddr, bready} !== {1'b1, 32'h2000, 1'b1}) begin n_fail++; $display("FAIL raw_concurrent got %h want %h", {arvalid, araddr, bready}, {1'b1, 32'h2000, 1'b1}); end
    arready = 1;
    @(negedge clk); arready = 0; rvalid = 1; rlast = 1; rdata = 32'h99; bvalid = 1; #1;
    n_chk++; if ({dc_ret_valid, dc_ret_data, ic_ret_valid} !== {1'b1, 32'h99, 1'b0}) begin n_fail++; $display("FAIL raw_ret got %h want %h", {dc_ret_valid, dc_ret_data, ic_ret_valid}, {1'b1, 32'h99, 1'b0}); end
    @(negedge clk); rvalid = 0; rlast = 0; bvalid = 0; #1;
    n_chk++; if ({dc_wr_rdy, rready} !== 2'b10) begin n_fail++; $display("FAIL raw_idle got %b want 10", {dc_wr_rdy, rready}); end
  endtask

  task test_reset_mid;
    @(negedge clk); ic_rd_req = 1; ic_rd_type = 3'b100; ic_rd_addr = 32'h1c000080;
    @(negedge clk); ic_rd_req = 0; arready = 1;
    @(negedge clk); arready = 0; rvalid = 1; rdata = 32'h11; rlast = 0; #1;
    n_chk++; if (ic_ret_valid !== 1'b1) begin n_fail++; $display("FAIL rm_beat1 got %b want 1", ic_ret_valid); end
    @(negedge clk); rdata = 32'h22; reset = 1; #1;
    n_chk++; if ({ic_rd_rdy, dc_rd_rdy, dc_wr_rdy} !== 3'b000) begin n_fail++; $display("FAIL rm_rst_rdy got %b want 000", {ic_rd_rdy, dc_rd_rdy, dc_wr_rdy}); end
    @(negedge clk); reset = 0; rvalid = 0; ic_rd_req = 1; ic_rd_type = 3'b010; ic_rd_addr = 32'h300; #1;
    n_chk++; if ({rready, ic_ret_valid, arvalid} !== 3'b000) begin n_fail++; $display("FAIL rm_abandon got %b want 000", {rready, ic_ret_valid, arvalid}); end
    n_chk++; if ({ic_rd_rdy, dc_wr_rdy} !== 2'b11) begin n_fail++; $display("FAIL rm_accept got %b want 11", {ic_rd_rdy, dc_wr_rdy}); end
    @(negedge clk); ic_rd_req = 0; #1;
    n_chk++; if ({arvalid, araddr, arlen} !== {1'b1, 32'h300, 8'd0}) begin n_fail++; $display("FAIL rm_new_ar got %h want %h", {arvalid, araddr, arlen}, {1'b1, 32'h300, 8'd0}); end
    arready = 1;
    @(negedge clk); arready = 0; rvalid = 1; rlast = 1;
    @(negedge clk); rvalid = 0; rlast = 0;
  endtask

  initial begin
    test_reset;
    test_ic_line_read;
    test_priority;
    test_line_write;
    test_byte_write;
    test_raw;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
